hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage MIPS core; next generation of the load-use / load-branch interlock.
//  Detects load-use, ALU-to-branch and load-to-branch RAW hazards against the instruction in ID.
//  Stalls for a parameter-set number of cycles, held by an FSM, then flushes IF/ID for taken branches.
//  Sits between the ID stage and the PC, IF/ID and ID/EX pipeline-register write enables.
// PARAMETERS
//  REG_AW          5  register-address width; address 0 is never a hazard source
//  LOAD_USE_STALL  1  stall cycles: non-branch consumer of a load in EX (>=1)
//  LOAD_BR_STALL   2  stall cycles: branch in ID consuming a load in EX (>=1)
//  LOADM_BR_STALL  1  stall cycles: branch in ID consuming a load in MEM (>=1)
//  ALU_BR_STALL    1  stall cycles: branch in ID consuming an ALU result in EX (>=1)
//  BR_FLUSH        1  IF/ID flush cycles after a taken branch (>=1)
// PORTS
//  clk           in   1       core clock
//  rst           in   1       synchronous, active-high reset
//  id_rs, id_rt  in   REG_AW  source registers of the instruction in ID
//  id_use_rs/rt  in   1       the instruction in ID reads rs / rt
//  id_is_branch  in   1       the instruction in ID is a branch resolved in ID
//  br_taken      in   1       the branch in ID resolves taken this cycle
//  ex_dst        in   REG_AW  destination register of the instruction in EX
//  ex_reg_write  in   1       the instruction in EX writes the register file
//  ex_mem_read   in   1       the instruction in EX is a load
//  mem_dst       in   REG_AW  destination register of the instruction in MEM
//  mem_mem_read  in   1       the instruction in MEM is a load
//  pc_write      out  1       PC load enable
//  ifid_write    out  1       IF/ID load enable
//  id_bubble     out  1       zero the ID/EX control fields (insert NOP)
//  ifid_flush    out  1       load NOP into IF/ID
//  stalled       out  1       state != IDLE (debug)
// BEHAVIOUR
//  match(x,d) = use_x & (x==d) & (d!=0). Hazard class in IDLE is combinational (same-cycle effect):
//   LU : ex_mem_read & match(rs|rt, ex_dst) & !id_is_branch   -> N=LOAD_USE_STALL
//   LB : ex_mem_read & match(.., ex_dst) & id_is_branch       -> N=LOAD_BR_STALL
//   LMB: mem_mem_read & match(.., mem_dst) & id_is_branch     -> N=LOADM_BR_STALL
//   AB : ex_reg_write & !ex_mem_read & match(..,ex_dst) & id_is_branch -> N=ALU_BR_STALL
//   If several classes fire, N = the maximum.
//  Stall cycle outputs: pc_write=0, ifid_write=0, id_bubble=1, ifid_flush=0.
//  FSM states: IDLE, STALL, FLUSH. The counter cnt is $clog2(max param + 1) bits wide.
//   IDLE, hazard with N: stall outputs this cycle; N>1 -> STALL, cnt=N-1; else stay in IDLE.
//   IDLE, no hazard, id_is_branch & br_taken: ifid_flush=1, pc_write=1, ifid_write=1;
//    BR_FLUSH>1 -> FLUSH, cnt=BR_FLUSH-1.
//   IDLE, otherwise: pc_write=1, ifid_write=1, id_bubble=0, ifid_flush=0.
//   STALL: stall outputs; all inputs are ignored; cnt decrements; cnt==1 -> IDLE at the next edge.
//   FLUSH: ifid_flush=1, pc_write=1, ifid_write=1, id_bubble=0; cnt==1 -> IDLE.
//  A hazard always beats br_taken: a branch with unresolved operands is never acted on.
//  Hazards are re-evaluated on return to IDLE. Producers have advanced by then, so no double count.
//  Reset: while rst=1, outputs are pc_write=0, ifid_write=0, id_bubble=1, ifid_flush=1, stalled=0.
//   At the next edge: state=IDLE, cnt=0. Reset mid-STALL or mid-FLUSH aborts the sequence.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: adds out ports stall_cycles[31:0] and flush_cycles[31:0].
//   They count cycles with id_bubble=1 / ifid_flush=1 outside reset, saturate at 2^32-1 and clear on rst.
//  Undefined: the ports and counters are absent; no other behavioural change.
// STRUCTURE
//  Shared header hazard_defs.vh: state encodings (IDLE=2'd0, STALL=2'd1, FLUSH=2'd2) and HAZ_ZERO_REG=0.
//  Sub-module reg_match: combinational rs/rt vs dst comparator with use/zero qualification.
//   Four instances: LU/LB and AB share the ex_dst pair; LMB uses mem_dst.
// TESTING
//  1 lw $2 in EX (ex_dst=2), add uses rs=2 -> 1 cycle pc_write=0, id_bubble=1, then IDLE.
//  2 lw $3 in EX, beq rt=3 in ID -> 2 cycles of stall (STALL entered, cnt=1), then IDLE; beq taken -> 1 flush.
//  3 add $4 in EX, beq rs=4 -> 1 stall; lw $4 in MEM, beq rs=4 -> 1 stall; ex_dst=0 with rs=0 -> no stall.
//  4 beq taken, no hazard, BR_FLUSH=3 -> ifid_flush=1 for 3 cycles with pc_write=1.
//  5 rst asserted mid-STALL with cnt=1 -> reset outputs, then IDLE; a new hazard the next cycle stalls afresh.
//  6 HAZ_PERF_CNT_EN: scenario 2 gives stall_cycles=2, flush_cycles=1; the ports are absent when undefined.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller: FSM encoding, zero register, helpers.
// Pure declarations; no timing and no flow control.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int HAZ_ZERO_REG = 0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_reg_match.sv
// Single-source RAW comparator: source is read, equals the producer's destination, and is not $0.
// Combinational (zero latency); no flow control.
module hazard_stall_ctrl_reg_match
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_use,
    input  logic [REG_AW-1:0] i_dst,
    output logic              o_match
);

    assign o_match = i_use & (i_src == i_dst) & (i_dst != REG_AW'(HAZ_ZERO_REG));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / ALU-branch / load-branch interlock: same-cycle stall, FSM-held multi-cycle stall, IF/ID flush.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush cycle counters; stall holds PC and IF/ID and bubbles ID/EX.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int LOAD_BR_STALL  = 2,
    parameter int LOADM_BR_STALL = 1,
    parameter int ALU_BR_STALL   = 1,
    parameter int BR_FLUSH       = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_use_rs,
    input  logic              i_id_use_rt,
    input  logic              i_id_is_branch,
    input  logic              i_br_taken,
    input  logic [REG_AW-1:0] i_ex_dst,
    input  logic              i_ex_reg_write,
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_mem_dst,
    input  logic              i_mem_mem_read,
    output logic              o_pc_write,
    output logic              o_ifid_write,
    output logic              o_id_bubble,
    output logic              o_ifid_flush,
`ifdef HAZ_PERF_CNT_EN
    output logic              o_stalled,
    output logic [31:0]       o_stall_cycles,
    output logic [31:0]       o_flush_cycles
`else
    output logic              o_stalled
`endif
);

    localparam int MAX_N = max_int(max_int(max_int(LOAD_USE_STALL, LOAD_BR_STALL),
                                           max_int(LOADM_BR_STALL, ALU_BR_STALL)), BR_FLUSH);
    localparam int CNT_W = $clog2(MAX_N + 1);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_LU  = CNT_W'(LOAD_USE_STALL);
    localparam logic [CNT_W-1:0] C_LB  = CNT_W'(LOAD_BR_STALL);
    localparam logic [CNT_W-1:0] C_LMB = CNT_W'(LOADM_BR_STALL);
    localparam logic [CNT_W-1:0] C_AB  = CNT_W'(ALU_BR_STALL);
    localparam logic [CNT_W-1:0] C_BRF = CNT_W'(BR_FLUSH);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
    logic w_ex_hit, w_mem_hit;
    logic w_lu, w_lb, w_lmb, w_ab, w_haz, w_br_go;
    logic [CNT_W-1:0] w_haz_n;

    hazard_stall_ctrl_reg_match #(.REG_AW(REG_AW)) u_rs_ex (
        .i_src(i_id_rs), .i_use(i_id_use_rs), .i_dst(i_ex_dst), .o_match(w_rs_ex)
    );
    hazard_stall_ctrl_reg_match #(.REG_AW(REG_AW)) u_rt_ex (
        .i_src(i_id_rt), .i_use(i_id_use_rt), .i_dst(i_ex_dst), .o_match(w_rt_ex)
    );
    hazard_stall_ctrl_reg_match #(.REG_AW(REG_AW)) u_rs_mem (
        .i_src(i_id_rs), .i_use(i_id_use_rs), .i_dst(i_mem_dst), .o_match(w_rs_mem)
    );
    hazard_stall_ctrl_reg_match #(.REG_AW(REG_AW)) u_rt_mem (
        .i_src(i_id_rt), .i_use(i_id_use_rt), .i_dst(i_mem_dst), .o_match(w_rt_mem)
    );

    assign w_ex_hit  = w_rs_ex | w_rt_ex;
    assign w_mem_hit = w_rs_mem | w_rt_mem;

    assign w_lu  = i_ex_mem_read & w_ex_hit & ~i_id_is_branch;
    assign w_lb  = i_ex_mem_read & w_ex_hit & i_id_is_branch;
    assign w_lmb = i_mem_mem_read & w_mem_hit & i_id_is_branch;
    assign w_ab  = i_ex_reg_write & ~i_ex_mem_read & w_ex_hit & i_id_is_branch;
    assign w_haz = w_lu | w_lb | w_lmb | w_ab;

    // A hazard suppresses the branch: its operands are not yet valid.
    assign w_br_go = ~w_haz & i_id_is_branch & i_br_taken;

    always_comb begin
        w_haz_n = '0;
        if (w_lu  && (C_LU  > w_haz_n)) w_haz_n = C_LU;
        if (w_lb  && (C_LB  > w_haz_n)) w_haz_n = C_LB;
        if (w_lmb && (C_LMB > w_haz_n)) w_haz_n = C_LMB;
        if (w_ab  && (C_AB  > w_haz_n)) w_haz_n = C_AB;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_haz) begin
                    if (w_haz_n > C_ONE) begin
                        w_state_nxt = ST_STALL;
                        w_cnt_nxt   = w_haz_n - C_ONE;
                    end
                end else if (w_br_go && (C_BRF > C_ONE)) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = C_BRF - C_ONE;
                end
            end
            ST_STALL, ST_FLUSH: begin
                w_cnt_nxt = r_cnt - C_ONE;
                if (r_cnt == C_ONE) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        o_pc_write   = 1'b1;
        o_ifid_write = 1'b1;
        o_id_bubble  = 1'b0;
        o_ifid_flush = 1'b0;
        o_stalled    = (r_state != ST_IDLE);
        if (i_rst) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_id_bubble  = 1'b1;
            o_ifid_flush = 1'b1;
            o_stalled    = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_haz) begin
                        o_pc_write   = 1'b0;
                        o_ifid_write = 1'b0;
                        o_id_bubble  = 1'b1;
                    end else if (w_br_go) begin
                        o_ifid_flush = 1'b1;
                    end
                end
                ST_STALL: begin
                    o_pc_write   = 1'b0;
                    o_ifid_write = 1'b0;
                    o_id_bubble  = 1'b1;
                end
                ST_FLUSH: o_ifid_flush = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_cycles;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (o_id_bubble && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (o_ifid_flush && (r_flush_cycles != '1)) r_flush_cycles <= r_flush_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_cycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed table, hand sequences, randomized run against a cycle-count model.
module tb_hazard_stall_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       br;
        logic       taken;
        logic [4:0] ex_dst;
        logic       ex_rw;
        logic       ex_mr;
        logic [4:0] mem_dst;
        logic       mem_mr;
    } in_t;

    typedef struct {
        in_t        i;
        logic [4:0] exp;
    } vec_t;

    // Output packing: {pc_write, ifid_write, id_bubble, ifid_flush, stalled}
    localparam logic [4:0] O_RST   = 5'b00110;
    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_HAZ   = 5'b00100;
    localparam logic [4:0] O_STALL = 5'b00101;
    localparam logic [4:0] O_BR    = 5'b11010;
    localparam logic [4:0] O_FLUSH = 5'b11011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t  cur = '0;
    logic pc0, ifw0, bub0, fl0, st0;
    logic pc1, ifw1, bub1, fl1, st1;
    logic [4:0] out0, out1;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] sc0, fc0, sc1, fc1;
`endif

    assign out0 = {pc0, ifw0, bub0, fl0, st0};
    assign out1 = {pc1, ifw1, bub1, fl1, st1};

    hazard_stall_ctrl dut0 (
        .i_clk(clk), .i_rst(cur.rst),
        .i_id_rs(cur.rs), .i_id_rt(cur.rt),
        .i_id_use_rs(cur.use_rs), .i_id_use_rt(cur.use_rt),
        .i_id_is_branch(cur.br), .i_br_taken(cur.taken),
        .i_ex_dst(cur.ex_dst), .i_ex_reg_write(cur.ex_rw), .i_ex_mem_read(cur.ex_mr),
        .i_mem_dst(cur.mem_dst), .i_mem_mem_read(cur.mem_mr),
        .o_pc_write(pc0), .o_ifid_write(ifw0), .o_id_bubble(bub0), .o_ifid_flush(fl0),
`ifdef HAZ_PERF_CNT_EN
        .o_stalled(st0), .o_stall_cycles(sc0), .o_flush_cycles(fc0)
`else
        .o_stalled(st0)
`endif
    );

    hazard_stall_ctrl #(.BR_FLUSH(3)) dut1 (
        .i_clk(clk), .i_rst(cur.rst),
        .i_id_rs(cur.rs), .i_id_rt(cur.rt),
        .i_id_use_rs(cur.use_rs), .i_id_use_rt(cur.use_rt),
        .i_id_is_branch(cur.br), .i_br_taken(cur.taken),
        .i_ex_dst(cur.ex_dst), .i_ex_reg_write(cur.ex_rw), .i_ex_mem_read(cur.ex_mr),
        .i_mem_dst(cur.mem_dst), .i_mem_mem_read(cur.mem_mr),
        .o_pc_write(pc1), .o_ifid_write(ifw1), .o_id_bubble(bub1), .o_ifid_flush(fl1),
`ifdef HAZ_PERF_CNT_EN
        .o_stalled(st1), .o_stall_cycles(sc1), .o_flush_cycles(fc1)
`else
        .o_stalled(st1)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Reference model: remaining stall / flush cycles per DUT, nothing else.
    int m_stall [2] = '{0, 0};
    int m_flush [2] = '{0, 0};
    int m_brf   [2] = '{1, 3};

    function automatic in_t mk(input logic rst, input int rs, input int rt,
                               input logic urs, input logic urt, input logic br, input logic tk,
                               input int exd, input logic exrw, input logic exmr,
                               input int md, input logic mmr);
        in_t v;
        v.rst = rst; v.rs = 5'(rs); v.rt = 5'(rt); v.use_rs = urs; v.use_rt = urt;
        v.br = br; v.taken = tk; v.ex_dst = 5'(exd); v.ex_rw = exrw; v.ex_mr = exmr;
        v.mem_dst = 5'(md); v.mem_mr = mmr;
        return v;
    endfunction

    function automatic bit reads(input in_t v, input logic [4:0] d);
        return (d != 0) && ((v.use_rs && v.rs == d) || (v.use_rt && v.rt == d));
    endfunction

    function automatic int stall_need(input in_t v);
        int n = 0;
        if (v.ex_mr && reads(v, v.ex_dst) && !v.br)                n = (n > 1) ? n : 1;
        if (v.ex_mr && reads(v, v.ex_dst) && v.br)                 n = (n > 2) ? n : 2;
        if (v.mem_mr && reads(v, v.mem_dst) && v.br)               n = (n > 1) ? n : 1;
        if (v.ex_rw && !v.ex_mr && reads(v, v.ex_dst) && v.br)     n = (n > 1) ? n : 1;
        return n;
    endfunction

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, got, want);
        end
    endtask

    task automatic step(input in_t v);
        logic [4:0] exp;
        int n;
        @(posedge clk);
        #1;
        cur = v;
        cyc++;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (v.rst) begin
                exp = O_RST; m_stall[k] = 0; m_flush[k] = 0;
            end else if (m_stall[k] > 0) begin
                exp = O_STALL; m_stall[k]--;
            end else if (m_flush[k] > 0) begin
                exp = O_FLUSH; m_flush[k]--;
            end else begin
                n = stall_need(v);
                if (n > 0) begin
                    exp = O_HAZ; m_stall[k] = n - 1;
                end else if (v.br && v.taken) begin
                    exp = O_BR; m_flush[k] = m_brf[k] - 1;
                end else begin
                    exp = O_RUN;
                end
            end
            if (k == 0) check("model_dut0", out0, exp);
            else        check("model_dut1", out1, exp);
        end
    endtask

    vec_t tbl [19];
    in_t  z;
    in_t  r;

    initial begin
        z = '0;
        tbl[0]  = '{mk(1, 0,0, 0,0, 0,0, 0,0,0, 0,0), O_RST};
        tbl[1]  = '{mk(0, 0,0, 0,0, 0,0, 0,0,0, 0,0), O_RUN};
        tbl[2]  = '{mk(0, 2,0, 1,0, 0,0, 2,1,1, 0,0), O_HAZ};
        tbl[3]  = '{mk(0, 2,0, 1,0, 0,0, 0,0,0, 0,0), O_RUN};
        tbl[4]  = '{mk(0, 0,3, 0,1, 1,1, 3,1,1, 0,0), O_HAZ};
        tbl[5]  = '{mk(0, 0,3, 0,1, 1,1, 0,0,0, 3,1), O_STALL};
        tbl[6]  = '{mk(0, 0,3, 0,1, 1,1, 0,0,0, 0,0), O_BR};
        tbl[7]  = '{mk(0, 4,0, 1,0, 1,1, 4,1,0, 0,0), O_HAZ};
        tbl[8]  = '{mk(0, 4,0, 1,0, 1,0, 0,0,0, 4,1), O_HAZ};
        tbl[9]  = '{mk(0, 0,0, 1,0, 1,0, 0,1,0, 0,0), O_RUN};
        tbl[10] = '{mk(0, 0,5, 0,0, 0,0, 5,1,1, 0,0), O_RUN};
        tbl[11] = '{mk(0, 6,7, 1,1, 1,0, 6,1,1, 7,1), O_HAZ};
        tbl[12] = '{mk(0, 6,7, 1,1, 1,0, 6,1,1, 7,1), O_STALL};
        tbl[13] = '{mk(0, 0,0, 0,0, 0,0, 0,0,0, 0,0), O_RUN};
        tbl[14] = '{mk(0, 0,3, 0,1, 1,0, 3,1,1, 0,0), O_HAZ};
        tbl[15] = '{mk(1, 0,3, 0,1, 1,0, 3,1,1, 0,0), O_RST};
        tbl[16] = '{mk(0, 2,0, 1,0, 1,0, 2,1,1, 0,0), O_HAZ};
        tbl[17] = '{mk(0, 0,0, 0,0, 0,0, 0,0,0, 0,0), O_STALL};
        tbl[18] = '{mk(0, 0,0, 0,0, 0,0, 0,0,0, 0,0), O_RUN};

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].i);
            check($sformatf("table_%0d", i), out0, tbl[i].exp);
        end

        // Taken branch with a three-cycle flush window.
        step(mk(0, 1,2, 1,1, 1,1, 0,0,0, 0,0));
        check("flush3_c0", out1, O_BR);
        step(z);
        check("flush3_c1", out1, O_FLUSH);
        step(z);
        check("flush3_c2", out1, O_FLUSH);
        step(z);
        check("flush3_done", out1, O_RUN);

`ifdef HAZ_PERF_CNT_EN
        step(mk(1, 0,0, 0,0, 0,0, 0,0,0, 0,0));
        step(z);
        n_vec++;
        if (sc0 !== 32'd0 || fc0 !== 32'd0) begin
            n_miss++;
            $display("FAIL perf_reset: got stall=%0d flush=%0d, expected 0/0", sc0, fc0);
        end
        step(tbl[4].i);
        step(tbl[5].i);
        step(tbl[6].i);
        step(z);
        n_vec++;
        if (sc0 !== 32'd2 || fc0 !== 32'd1) begin
            n_miss++;
            $display("FAIL perf_lb_branch: got stall=%0d flush=%0d, expected 2/1", sc0, fc0);
        end
`endif

        for (int i = 0; i < 3000; i++) begin
            r.rst     = ($urandom_range(0, 49) == 0);
            r.rs      = 5'($urandom_range(0, 3));
            r.rt      = 5'($urandom_range(0, 3));
            r.use_rs  = 1'($urandom);
            r.use_rt  = 1'($urandom);
            r.br      = 1'($urandom);
            r.taken   = 1'($urandom);
            r.ex_dst  = 5'($urandom_range(0, 3));
            r.ex_rw   = 1'($urandom);
            r.ex_mr   = 1'($urandom);
            r.mem_dst = 5'($urandom_range(0, 3));
            r.mem_mr  = 1'($urandom);
            step(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
